dcache_responder: RTL
=====================

DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning word-address bits (memory depth 2^ADDR_W x 32 bits).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of clock edges from request acceptance to dcache_valid (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port dcache_r_ena, input, 1 bit: read request, held by the initiator until dcache_valid.
REQ-006 The block SHALL have port dcache_w_ena, input, 1 bit: write request, held by the initiator until dcache_valid.
REQ-007 The block SHALL have port dcache_ext, input, 1 bit: 1 = sign-extend read data, 0 = zero-extend.
REQ-008 The block SHALL have port dcache_width, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = treated as word.
REQ-009 The block SHALL have port dcache_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port dcache_data_in, input, 32 bits: write data, right-aligned.
REQ-011 The block SHALL have port dcache_valid, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port dcache_data_out, output, 32 bits: extended read data.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-014 In IDLE, a rising edge with r_ena or w_ena high SHALL accept the request: it latches addr, width, ext and data_in, loads a counter with LATENCY-1 and moves to WAIT, or to RESP if LATENCY=1.
REQ-015 In WAIT, the counter SHALL decrement each edge; at 0 the FSM moves to RESP.
REQ-016 In RESP, dcache_valid SHALL be 1 for exactly that cycle; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-017 Inputs SHALL be ignored outside IDLE; a request still held during RESP is re-accepted only at the following IDLE edge, giving minimum back-to-back spacing of LATENCY+1 cycles.
REQ-018 The word index SHALL be addr[ADDR_W+1:2]; upper bits are ignored, so addresses wrap modulo 2^(ADDR_W+2).
REQ-019 Byte accesses SHALL select lane addr[1:0]; half accesses SHALL select lane addr[1] (addr[0] ignored); word accesses SHALL ignore addr[1:0].
REQ-020 A write SHALL commit at the acceptance edge, updating only the selected lanes from the low bits of data_in.
REQ-021 A read SHALL sample memory at the acceptance edge; a write accepted earlier is visible.
REQ-022 When r_ena and w_ena are both high, the request SHALL be treated as a write.
REQ-023 For reads, data_out SHALL be set at the RESP entry edge to the selected lane, sign- or zero-extended per latched ext, and SHALL hold until the next read completes.
REQ-024 For writes, data_out SHALL be driven to 0 at RESP entry.
REQ-025 dcache_valid SHALL be registered with no combinational path from any input.

Reset
REQ-026 While rst is 0, the FSM SHALL be IDLE, the counter 0, dcache_valid 0 and dcache_data_out 0, applied immediately and asynchronously.
REQ-027 Reset asserted mid-transaction SHALL abort it with no valid pulse; a write already committed remains in memory.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 The first acceptance after reset SHALL occur on the first rising edge with rst=1 and a request high.

Verification
REQ-030 Word round-trip, LATENCY=2: write 0xDEADBEEF to 0x100, then word read of 0x100 -> valid exactly 2 edges after each acceptance; data_out=0xDEADBEEF on the read, 0 on the write.
REQ-031 Byte and half extension: after the scenario in REQ-030, byte read 0x103 with ext=1 -> 0xFFFFFFDE; with ext=0 -> 0x000000DE; half read 0x100 with ext=1 -> 0xFFFFBEEF.
REQ-032 Partial write: byte write 0x55 to 0x101, then word read 0x100 -> 0xDEAD55EF.
REQ-033 Back-to-back held r_ena with LATENCY=1 -> valid on alternate cycles; simultaneous r_ena=w_ena=1 -> memory written, data_out=0.
REQ-034 Wrap and reset: write to 0x1000 with ADDR_W=10, read from 0x0 -> same data; assert rst in WAIT -> valid never pulses, data_out=0, and the next request completes normally.

Source files
------------

// File: rtl/dcache_responder.sv
// Fixed-latency data-cache responder backed by a word-organised memory.
// Requests are accepted in IDLE, complete LATENCY edges later with a one-cycle dcache_valid pulse.
module dcache_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dcache_r_ena,
  input  logic        dcache_w_ena,
  input  logic        dcache_ext,
  input  logic [1:0]  dcache_width,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_data_in,
  output logic        dcache_valid,
  output logic [31:0] dcache_data_out
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam logic        LAT1  = (LATENCY == 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        mem [DEPTH];
  logic [ADDR_W-1:0]  idx_c;
  logic               accept_c;
  logic [31:0]        rd_ext_c;
  logic [31:0]        resp_data_c;
  logic [3:0]         be_c;
  logic [31:0]        wdata_c;
  logic [31:0]        lat_rd_q;
  logic               lat_wr_q;
  logic               unused_addr_c;

  // Addresses wrap: bits above the word index carry no meaning.
  assign unused_addr_c = ^dcache_addr[31:ADDR_W+2];

  // Select the addressed lane of a word and extend it to 32 bits.
  function automatic logic [31:0] extend_lane(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] width, input logic sx);
    logic [31:0] sh;
    case (width)
      2'b00: begin
        sh = word >> {off, 3'b000};
        return {{24{sx & sh[7]}}, sh[7:0]};
      end
      2'b01: begin
        sh = word >> {off[1], 4'b0000};
        return {{16{sx & sh[15]}}, sh[15:0]};
      end
      default: return word;
    endcase
  endfunction

  assign idx_c    = dcache_addr[ADDR_W+1:2];
  assign accept_c = (state_q == IDLE) && (dcache_r_ena || dcache_w_ena);
  assign rd_ext_c = extend_lane(mem[idx_c], dcache_addr[1:0], dcache_width, dcache_ext);

  // Byte enables and lane-replicated write data.
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = dcache_data_in;
    case (dcache_width)
      2'b00: begin
        be_c    = 4'b0001 << dcache_addr[1:0];
        wdata_c = {4{dcache_data_in[7:0]}};
      end
      2'b01: begin
        be_c    = dcache_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{dcache_data_in[15:0]}};
      end
      default: be_c = 4'b1111;
    endcase
  end

  // Memory is deliberately not reset; writes commit at the acceptance edge.
  always_ff @(posedge clk) begin
    if (rst && accept_c && dcache_w_ena) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[idx_c][8*i +: 8] <= wdata_c[8*i +: 8];
      end
    end
  end

  // Next state, counter and the value presented at RESP entry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    resp_data_c = lat_wr_q ? 32'h0 : lat_rd_q;
    case (state_q)
      IDLE: begin
        // With LATENCY=1 RESP is entered on the acceptance edge itself.
        resp_data_c = dcache_w_ena ? 32'h0 : rd_ext_c;
        if (accept_c) begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = LAT1 ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      dcache_valid    <= 1'b0;
      dcache_data_out <= 32'h0;
      lat_rd_q        <= 32'h0;
      lat_wr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dcache_valid <= (state_d == RESP);
      if (state_d == RESP) dcache_data_out <= resp_data_c;
      if (accept_c) begin
        lat_rd_q <= rd_ext_c;
        lat_wr_q <= dcache_w_ena;
      end
    end
  end

endmodule
